// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the EX stage and its multiply/divide unit.
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int ADW = 5;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLT    = 5'd5,
        ALU_SLTU   = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_mul_op(alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_rem_op(alu_op_t op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_signed_div(alu_op_t op);
        return op inside {ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/ex_stage_mdu_mdu.sv
// Iterative multiply/divide unit: one-cycle multiply, DPW-step restoring divide.
// start is only honoured in IDLE; result is valid while done is high.
module mdu
    import rv32i_pkg::*;
#(
    parameter int DPW = rv32i_pkg::DPW
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           start,
    input  logic           flush,
    input  alu_op_t        op,
    input  logic [DPW-1:0] opA,
    input  logic [DPW-1:0] opB,
    output logic           busy,
    output logic           done,
    output logic [DPW-1:0] result
);

    localparam int CW = $clog2(DPW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DPW - 1);

    mdu_state_t state, nextState;

    alu_op_t          opR;
    logic [DPW:0]     mulA, mulB;
    logic [2*DPW-1:0] prodR;
    logic [DPW-1:0]   remR, quoR, divR;
    logic             negQ, negR;
    logic [CW-1:0]    cnt;

    logic             aSigned, bSigned, divSgn;
    logic [DPW-1:0]   absA, absB;
    logic [2*DPW-1:0] wideA, wideB, prodNext;
    logic [DPW:0]     remShift;
    logic             divGe;
    logic [DPW-1:0]   remSub;

    // Operand interpretation and magnitudes, evaluated on the start cycle
    always_comb begin
        aSigned = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU};
        bSigned = op inside {ALU_MUL, ALU_MULH};
        divSgn  = is_signed_div(op);
        absA    = (divSgn && opA[DPW-1]) ? -opA : opA;
        absB    = (divSgn && opB[DPW-1]) ? -opB : opB;
    end

    // One sign-extended multiply covers all four variants; only the low 2*DPW bits matter
    always_comb begin
        wideA    = {{(DPW-1){mulA[DPW]}}, mulA};
        wideB    = {{(DPW-1){mulB[DPW]}}, mulB};
        prodNext = wideA * wideB;
    end

    // Single restoring-division step on the partial remainder
    always_comb begin
        remShift = {remR, quoR[DPW-1]};
        divGe    = (remShift >= {1'b0, divR});
        remSub   = remShift[DPW-1:0] - divR;
    end

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= MDU_IDLE;
        else         state <= nextState;
    end

    // Next-state logic; flush abandons any operation in flight
    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = MDU_IDLE;
        end else begin
            case (state)
                MDU_IDLE: if (start) nextState = is_mul_op(op) ? MDU_MUL : MDU_DIV;
                MDU_MUL:  nextState = MDU_DONE;
                MDU_DIV:  if (cnt == CNT_LAST) nextState = MDU_DONE;
                MDU_DONE: nextState = MDU_IDLE;
                default:  nextState = MDU_IDLE;
            endcase
        end
    end

    // Output logic: handshake flags and sign-corrected result
    always_comb begin
        busy   = (state == MDU_MUL) || (state == MDU_DIV);
        done   = (state == MDU_DONE);
        result = '0;
        if (state == MDU_DONE) begin
            case (opR)
                ALU_MUL:                        result = prodR[DPW-1:0];
                ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prodR[2*DPW-1:DPW];
                ALU_DIV, ALU_DIVU:              result = negQ ? -quoR : quoR;
                ALU_REM, ALU_REMU:              result = negR ? -remR : remR;
                default:                        result = '0;
            endcase
        end
    end

    // Datapath registers: capture on start, then multiply or iterate
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            opR   <= ALU_ADD;
            mulA  <= '0;
            mulB  <= '0;
            prodR <= '0;
            remR  <= '0;
            quoR  <= '0;
            divR  <= '0;
            negQ  <= 1'b0;
            negR  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        opR  <= op;
                        mulA <= {aSigned & opA[DPW-1], opA};
                        mulB <= {bSigned & opB[DPW-1], opB};
                        remR <= '0;
                        quoR <= absA;
                        divR <= absB;
                        negQ <= divSgn & (opA[DPW-1] ^ opB[DPW-1]);
                        negR <= divSgn & opA[DPW-1];
                        cnt  <= '0;
                    end
                end
                MDU_MUL: prodR <= prodNext;
                MDU_DIV: begin
                    remR <= divGe ? remSub : remShift[DPW-1:0];
                    quoR <= {quoR[DPW-2:0], divGe};
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, branch target and an
// optional multi-cycle multiply/divide unit that stalls the front of the pipe.
module ex_stage_mdu
    import rv32i_pkg::*;
#(
    parameter int DPW    = rv32i_pkg::DPW,
    parameter int ADW    = rv32i_pkg::ADW,
    parameter int MDU_EN = 1
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           valid_i,
    input  logic           flush_i,
    input  alu_op_t        alu_ctrl_i,
    input  logic           alusrc_i,
    input  logic [DPW-1:0] rd1_i,
    input  logic [DPW-1:0] rd2_i,
    input  logic [DPW-1:0] immext_i,
    input  logic [DPW-1:0] pc_i,
    input  logic [ADW-1:0] rdaddr_i,
    input  fwd_sel_t       fwdA_i,
    input  fwd_sel_t       fwdB_i,
    input  logic [DPW-1:0] aluresultM_i,
    input  logic [DPW-1:0] resultW_i,
    output logic           stall_o,
    output logic           valid_o,
    output logic [DPW-1:0] aluresult_o,
    output logic [DPW-1:0] writedata_o,
    output logic [DPW-1:0] pctarget_o,
    output logic           zero_o,
    output logic [ADW-1:0] rdaddr_o
);

    localparam int SHW = $clog2(DPW);
    localparam logic [DPW-1:0] SMIN = {1'b1, {(DPW-1){1'b0}}};

    logic [DPW-1:0] srcA, fwdB, srcB, aluRes, exResult, specialRes, pcTarget;
    logic [SHW-1:0] shamt;
    logic           isMOp, isDivOp, isRemOp, divSigned, divByZero, divOvf, special;
    logic           mduStart, mduBusy, mduDone;
    logic [DPW-1:0] mduResult;
    logic [ADW-1:0] rdaddrHold;
    logic [DPW-1:0] wdHold, pcTgtHold;

    // Forwarding muxes; the reserved select falls back to the register file
    always_comb begin
        case (fwdA_i)
            FWD_WB:  srcA = resultW_i;
            FWD_MEM: srcA = aluresultM_i;
            default: srcA = rd1_i;
        endcase
        case (fwdB_i)
            FWD_WB:  fwdB = resultW_i;
            FWD_MEM: fwdB = aluresultM_i;
            default: fwdB = rd2_i;
        endcase
        srcB     = alusrc_i ? immext_i : fwdB;
        shamt    = srcB[SHW-1:0];
        pcTarget = pc_i + immext_i;
    end

    // Single-cycle ALU
    always_comb begin
        case (alu_ctrl_i)
            ALU_ADD:  aluRes = srcA + srcB;
            ALU_SUB:  aluRes = srcA - srcB;
            ALU_AND:  aluRes = srcA & srcB;
            ALU_OR:   aluRes = srcA | srcB;
            ALU_XOR:  aluRes = srcA ^ srcB;
            ALU_SLT:  aluRes = {{(DPW-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            ALU_SLTU: aluRes = {{(DPW-1){1'b0}}, srcA < srcB};
            ALU_SLL:  aluRes = srcA << shamt;
            ALU_SRL:  aluRes = srcA >> shamt;
            ALU_SRA:  aluRes = $signed(srcA) >>> shamt;
            default:  aluRes = '0;
        endcase
    end

    // Divide corner cases resolve here in one cycle and never reach the MDU
    always_comb begin
        isMOp      = is_mul_op(alu_ctrl_i) | is_div_op(alu_ctrl_i);
        isDivOp    = is_div_op(alu_ctrl_i);
        isRemOp    = is_rem_op(alu_ctrl_i);
        divSigned  = is_signed_div(alu_ctrl_i);
        divByZero  = (srcB == '0);
        divOvf     = divSigned & (srcA == SMIN) & (srcB == '1);
        special    = isDivOp & (divByZero | divOvf);
        if (divByZero) specialRes = isRemOp ? srcA : '1;
        else           specialRes = isRemOp ? '0 : SMIN;
        if (isMOp) exResult = ((MDU_EN != 0) && special) ? specialRes : '0;
        else       exResult = aluRes;
    end

    // Reset is folded in so stall_o reads 0 while reset is held
    assign mduStart = arst_n & valid_i & ~flush_i & isMOp & ~special
                    & ~mduBusy & ~mduDone & (MDU_EN != 0);
    assign stall_o  = mduStart | mduBusy;

    generate
        if (MDU_EN != 0) begin : g_mdu
            mdu #(.DPW(DPW)) u_mdu (
                .clk    (clk),
                .arst_n (arst_n),
                .start  (mduStart),
                .flush  (flush_i),
                .op     (alu_ctrl_i),
                .opA    (srcA),
                .opB    (srcB),
                .busy   (mduBusy),
                .done   (mduDone),
                .result (mduResult)
            );
        end else begin : g_nomdu
            assign mduBusy   = 1'b0;
            assign mduDone   = 1'b0;
            assign mduResult = '0;
        end
    endgenerate

    // Side-band fields of an accepted M op, held while the pipe is stalled
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdaddrHold <= '0;
            wdHold     <= '0;
            pcTgtHold  <= '0;
        end else if (mduStart) begin
            rdaddrHold <= rdaddr_i;
            wdHold     <= fwdB;
            pcTgtHold  <= pcTarget;
        end
    end

    // EX/MEM register: flush first, then MDU completion, then ALU results
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_o     <= 1'b0;
            aluresult_o <= '0;
            writedata_o <= '0;
            pctarget_o  <= '0;
            zero_o      <= 1'b0;
            rdaddr_o    <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (mduDone) begin
            valid_o     <= 1'b1;
            aluresult_o <= mduResult;
            zero_o      <= (mduResult == '0);
            writedata_o <= wdHold;
            pctarget_o  <= pcTgtHold;
            rdaddr_o    <= rdaddrHold;
        end else if (mduStart || mduBusy) begin
            valid_o <= 1'b0;
        end else if (valid_i) begin
            valid_o     <= 1'b1;
            aluresult_o <= exResult;
            zero_o      <= (exResult == '0);
            writedata_o <= fwdB;
            pctarget_o  <= pcTarget;
            rdaddr_o    <= rdaddr_i;
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu with hand-computed expectations.
module tb_ex_stage_mdu;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    alu_op_t     alu_ctrl_i = ALU_ADD;
    logic        alusrc_i = 1'b0;
    logic [31:0] rd1_i = '0, rd2_i = '0, immext_i = '0, pc_i = '0;
    logic [4:0]  rdaddr_i = '0;
    fwd_sel_t    fwdA_i = FWD_RF, fwdB_i = FWD_RF;
    logic [31:0] aluresultM_i = '0, resultW_i = '0;
    logic        stall_o, valid_o, zero_o;
    logic [31:0] aluresult_o, writedata_o, pctarget_o;
    logic [4:0]  rdaddr_o;

    int nCmp = 0;
    int nErr = 0;

    ex_stage_mdu #(.DPW(32), .ADW(5), .MDU_EN(1)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .alusrc_i     (alusrc_i),
        .rd1_i        (rd1_i),
        .rd2_i        (rd2_i),
        .immext_i     (immext_i),
        .pc_i         (pc_i),
        .rdaddr_i     (rdaddr_i),
        .fwdA_i       (fwdA_i),
        .fwdB_i       (fwdB_i),
        .aluresultM_i (aluresultM_i),
        .resultW_i    (resultW_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .aluresult_o  (aluresult_o),
        .writedata_o  (writedata_o),
        .pctarget_o   (pctarget_o),
        .zero_o       (zero_o),
        .rdaddr_o     (rdaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        valid_i    = 1'b1;
        alu_ctrl_i = op;
        rd1_i      = a;
        rd2_i      = b;
        fwdA_i     = FWD_RF;
        fwdB_i     = FWD_RF;
        alusrc_i   = 1'b0;
        immext_i   = '0;
        rdaddr_i   = 5'd1;
        #1;
    endtask

    // Single-cycle op: no stall, result on the next edge
    task automatic aluVec(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
        tick();
        chk(tag, 64'(aluresult_o), 64'(exp));
        chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    endtask

    // Multi-cycle op: stall at acceptance, then count stall cycles and latency
    // from the acceptance edge while the inputs are scrambled.
    task automatic runM(input string tag, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int expLat, input int expStall);
        int lat = 0;
        int st  = 0;
        drive(op, a, b);
        rdaddr_i = 5'd9;
        #1;
        chk({tag, "_accept_stall"}, 64'(stall_o), 64'd1);
        tick();
        rd1_i    = 32'h0BAD_F00D;
        rd2_i    = 32'h0000_0001;
        rdaddr_i = 5'd3;
        for (int c = 1; c <= 100; c++) begin
            if (stall_o) st++;
            tick();
            if (valid_o) begin
                lat = c;
                break;
            end
        end
        valid_i = 1'b0;
        chk(tag, 64'(aluresult_o), 64'(exp));
        chk({tag, "_latency"}, 64'(lat), 64'(expLat));
        chk({tag, "_stalls"}, 64'(st), 64'(expStall));
        chk({tag, "_rd"}, 64'(rdaddr_o), 64'd9);
        chk({tag, "_wd"}, 64'(writedata_o), 64'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 arst_n = 1'b0;
        #12;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", 64'(aluresult_o), 64'd0);
        chk("rst_zero", 64'(zero_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_rd", 64'(rdaddr_o), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // MEM forward on A, immediate on B, branch target and store data
        valid_i      = 1'b1;
        alu_ctrl_i   = ALU_ADD;
        rd1_i        = 32'd5;
        fwdA_i       = FWD_MEM;
        aluresultM_i = 32'h10;
        alusrc_i     = 1'b1;
        immext_i     = 32'd3;
        rd2_i        = 32'h55;
        fwdB_i       = FWD_RF;
        pc_i         = 32'h100;
        rdaddr_i     = 5'd7;
        #1;
        chk("fwd_add_stall", 64'(stall_o), 64'd0);
        tick();
        chk("fwd_add", 64'(aluresult_o), 64'h13);
        chk("fwd_add_valid", 64'(valid_o), 64'd1);
        chk("fwd_add_wd", 64'(writedata_o), 64'h55);
        chk("fwd_add_pct", 64'(pctarget_o), 64'h103);
        chk("fwd_add_rd", 64'(rdaddr_o), 64'd7);
        chk("fwd_add_zero", 64'(zero_o), 64'd0);

        // WB forward on B producing zero
        drive(ALU_SUB, 32'h20, 32'h0);
        fwdB_i    = FWD_WB;
        resultW_i = 32'h20;
        #1;
        tick();
        chk("wb_sub", 64'(aluresult_o), 64'd0);
        chk("wb_sub_zero", 64'(zero_o), 64'd1);
        chk("wb_sub_wd", 64'(writedata_o), 64'h20);

        // Reserved forward select reads the register file
        drive(ALU_ADD, 32'd9, 32'd1);
        fwdA_i = FWD_RSVD;
        #1;
        tick();
        chk("rsvd_fwd", 64'(aluresult_o), 64'd10);

        // ALU operations
        aluVec("sub",  ALU_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE);
        aluVec("and",  ALU_AND,  32'hF0F0_00FF, 32'h0FF0_F0F0, 32'h00F0_00F0);
        aluVec("or",   ALU_OR,   32'hF0F0_00FF, 32'h0FF0_F0F0, 32'hFFF0_F0FF);
        aluVec("xor",  ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_F0F0, 32'hFF00_F00F);
        aluVec("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'd0, 32'd1);
        aluVec("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd0, 32'd0);
        aluVec("sltu2", ALU_SLTU, 32'd1, 32'd2, 32'd1);
        aluVec("sll",  ALU_SLL,  32'd1, 32'h21, 32'd2);
        aluVec("srl",  ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
        aluVec("sra",  ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);

        // Idle cycle holds data, drops valid
        valid_i = 1'b0;
        tick();
        chk("idle_valid", 64'(valid_o), 64'd0);
        chk("idle_hold", 64'(aluresult_o), 64'hF800_0000);

        // Multiply and divide
        runM("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1);
        runM("mul",    ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, 1);
        runM("mulh",   ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1);
        runM("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1);
        runM("div",    ALU_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        runM("rem",    ALU_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        runM("divu",   ALU_DIVU,   32'd100, 32'd7, 32'd14, 33, 32);
        runM("remu",   ALU_REMU,   32'd100, 32'd7, 32'd2, 33, 32);

        // Divide corner cases at ALU latency
        aluVec("divu_by0", ALU_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        aluVec("remu_by0", ALU_REMU, 32'h1234, 32'd0, 32'h1234);
        aluVec("rem_ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        aluVec("div_ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // Flush in the middle of a divide
        drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        tick();
        repeat (10) tick();
        flush_i = 1'b1;
        valid_i = 1'b0;
        tick();
        chk("flush_stall", 64'(stall_o), 64'd0);
        chk("flush_valid", 64'(valid_o), 64'd0);
        flush_i = 1'b0;
        aluVec("add_after_flush", ALU_ADD, 32'd1, 32'd1, 32'd2);

        // Asynchronous reset while in the multiply state
        drive(ALU_MUL, 32'd3, 32'd4);
        tick();
        arst_n = 1'b0;
        #1;
        chk("mrst_stall", 64'(stall_o), 64'd0);
        chk("mrst_valid", 64'(valid_o), 64'd0);
        chk("mrst_result", 64'(aluresult_o), 64'd0);
        chk("mrst_rd", 64'(rdaddr_o), 64'd0);
        chk("mrst_wd", 64'(writedata_o), 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        arst_n  = 1'b1;
        tick();
        aluVec("slt_post_rst", ALU_SLT, 32'hFFFF_FFFF, 32'd0, 32'd1);
        runM("mulhu_post_rst", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
